// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR register-file datapath.
// Opcode encoding matches the controller's registered command stream.
package fir_pkg;

  localparam int NUM_REGS = 16;
  localparam int REG_W    = 17;
  localparam int DATA_W   = 16;
  localparam int IDX_W    = 4;

  typedef enum logic [2:0] {
    OP_NOP         = 3'b000,
    OP_COPY        = 3'b001,
    OP_LOAD_SAMPLE = 3'b010,
    OP_LOAD_COEFF  = 3'b011,
    OP_ADD         = 3'b100,
    OP_SUB         = 3'b101,
    OP_MUL         = 3'b110,
    OP_RSVD        = 3'b111
  } op_e;

  localparam logic [IDX_W-1:0] ACC        = 4'd0;
  localparam logic [IDX_W-1:0] NEW_SAMPLE = 4'd5;
  localparam logic [IDX_W-1:0] COEFF_BASE = 4'd7;
  localparam logic [IDX_W-1:0] ZERO_REG   = 4'd11;

  function automatic logic op_writes(input op_e op);
    return (op != OP_NOP) && (op != OP_RSVD);
  endfunction

endpackage

// File: rtl/fir_alu.sv
// Combinational ALU for the FIR datapath: copy, loads, add/sub with
// signed overflow detect, and unsigned Q0.16 multiply (upper half).
module fir_alu
  import fir_pkg::*;
(
  input  op_e               op,
  input  logic [REG_W-1:0]  a,
  input  logic [REG_W-1:0]  b,
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] coeff,
  output logic [REG_W-1:0]  result,
  output logic              overflow
);

  logic [REG_W-1:0] w_sum;
  logic [REG_W-1:0] w_diff;
  logic [31:0]      w_prod;

  assign w_sum  = a + b;
  assign w_diff = a - b;
  assign w_prod = 32'(a[DATA_W-1:0]) * 32'(b[DATA_W-1:0]);

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (op)
      OP_COPY:        result = a;
      OP_LOAD_SAMPLE: result = {1'b0, sample};
      OP_LOAD_COEFF:  result = {1'b0, coeff};
      OP_ADD: begin
        result   = w_sum;
        overflow = (a[REG_W-1] == b[REG_W-1]) &&
                   (w_sum[REG_W-1] != a[REG_W-1]);
      end
      OP_SUB: begin
        result   = w_diff;
        overflow = (a[REG_W-1] != b[REG_W-1]) &&
                   (w_diff[REG_W-1] != a[REG_W-1]);
      end
      OP_MUL:         result = {1'b0, w_prod[31:16]};
      default: begin
        result   = '0;
        overflow = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/fir_datapath.sv
// FIR register-file datapath: 16x17-bit registers, two async read
// ports, one write port; R0 is the accumulator / filter output.
module fir_datapath
  import fir_pkg::*;
(
  input  logic              clk,
  input  logic              n_rst,
  input  logic [2:0]        op,
  input  logic [IDX_W-1:0]  src1,
  input  logic [IDX_W-1:0]  src2,
  input  logic [IDX_W-1:0]  dest,
  input  logic [DATA_W-1:0] sample_data,
  input  logic [DATA_W-1:0] coeff_data,
  output logic              overflow,
  output logic [REG_W-1:0]  outreg_data
);

  logic [REG_W-1:0] r_regs [NUM_REGS];

  op_e              w_op;
  logic [REG_W-1:0] w_rd1;
  logic [REG_W-1:0] w_rd2;
  logic [REG_W-1:0] w_result;
  logic             w_ovf;
  logic             w_we;

  assign w_op  = op_e'(op);
  assign w_rd1 = r_regs[src1];
  assign w_rd2 = r_regs[src2];
  assign w_we  = op_writes(w_op);

  fir_alu u_alu (
    .op       (w_op),
    .a        (w_rd1),
    .b        (w_rd2),
    .sample   (sample_data),
    .coeff    (coeff_data),
    .result   (w_result),
    .overflow (w_ovf)
  );

  // Reads see pre-edge contents, so dest==src collisions return old data.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_we) begin
      r_regs[dest] <= w_result;
    end
  end

  assign overflow    = w_ovf;
  assign outreg_data = r_regs[ACC];

endmodule

// File: tb/tb_fir_datapath.sv
// Scoreboard bench for fir_datapath: driver pushes expected R0/overflow
// from an arithmetic reference model, a negedge monitor compares.
module tb_fir_datapath;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [2:0]  op;
  logic [3:0]  src1, src2, dest;
  logic [15:0] sample_data, coeff_data;
  logic        overflow;
  logic [16:0] outreg_data;

  fir_datapath dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .op          (op),
    .src1        (src1),
    .src2        (src2),
    .dest        (dest),
    .sample_data (sample_data),
    .coeff_data  (coeff_data),
    .overflow    (overflow),
    .outreg_data (outreg_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [16:0] acc;
    logic        ovf;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   model[16];

  function automatic int to_signed(input int v);
    return (v >= 65536) ? v - 131072 : v;
  endfunction

  task automatic do_op(input int o, input int s1, input int s2,
                       input int d, input int sd, input int cd,
                       input string nm);
    exp_t e;
    int   a, b, s, res;
    bit   wr, ovf;
    longint p;
    @(posedge clk);
    #1;
    op = 3'(o); src1 = 4'(s1); src2 = 4'(s2); dest = 4'(d);
    sample_data = 16'(sd); coeff_data = 16'(cd);
    a = model[s1]; b = model[s2];
    wr = 1; ovf = 0; res = 0;
    case (o)
      1: res = a;
      2: res = sd;
      3: res = cd;
      4: begin
        s = to_signed(a) + to_signed(b);
        ovf = (s > 65535) || (s < -65536);
        res = (s + 131072) % 131072;
      end
      5: begin
        s = to_signed(a) - to_signed(b);
        ovf = (s > 65535) || (s < -65536);
        res = (s + 131072) % 131072;
      end
      6: begin
        p = longint'(a % 65536) * longint'(b % 65536);
        res = int'(p / 65536);
      end
      default: wr = 0;
    endcase
    e.acc = 17'(model[0]);
    e.ovf = ovf;
    e.name = nm;
    q.push_back(e);
    if (wr) model[d] = res;
  endtask

  task automatic observe(input int r, input string nm);
    do_op(1, r, 0, 0, 0, 0, nm);
    do_op(0, 0, 0, 0, 0, 0, nm);
  endtask

  always @(negedge clk) begin
    if (!n_rst) begin
      checks++;
      if (outreg_data !== 17'h0 || overflow !== 1'b0) begin
        errors++;
        $display("FAIL reset_state: outreg=%h ovf=%b want outreg=0 ovf=0",
                 outreg_data, overflow);
      end
    end else if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (outreg_data !== e.acc || overflow !== e.ovf) begin
        errors++;
        $display("FAIL %s: outreg=%h ovf=%b want outreg=%h ovf=%b",
                 e.name, outreg_data, overflow, e.acc, e.ovf);
      end
    end
  end

  initial begin
    n_rst = 1'b0;
    op = 3'd0; src1 = 4'd0; src2 = 4'd0; dest = 4'd0;
    sample_data = 16'd0; coeff_data = 16'd0;
    for (int i = 0; i < 16; i++) model[i] = 0;
    repeat (3) @(posedge clk);
    #2 n_rst = 1'b1;

    repeat (3) do_op(0, 0, 0, 0, 0, 0, "nop_after_reset");
    for (int r = 0; r < 16; r++) observe(r, "reg_zero_after_reset");

    do_op(2, 0, 0, 5, 16'h1234, 0, "load_sample");
    do_op(1, 5, 0, 1, 0, 0, "copy_r5_r1");
    observe(1, "copy_result");

    do_op(3, 0, 0, 7, 0, 16'h8000, "load_coeff");
    do_op(2, 0, 0, 1, 16'h8000, 0, "load_sample_8000");
    do_op(6, 1, 7, 6, 0, 0, "mul");
    observe(6, "mul_result");

    do_op(2, 0, 0, 0, 16'hFFFF, 0, "ld_r0_ffff");
    do_op(2, 0, 0, 6, 16'hFFFF, 0, "ld_r6_ffff");
    do_op(4, 0, 6, 0, 0, 0, "add_overflow");
    do_op(0, 0, 0, 0, 0, 0, "add_wrapped");

    do_op(2, 0, 0, 0, 5, 0, "ld_r0_5");
    do_op(2, 0, 0, 6, 9, 0, "ld_r6_9");
    do_op(5, 0, 6, 0, 0, 0, "sub_neg");
    do_op(0, 0, 0, 0, 0, 0, "sub_result");
    do_op(5, 11, 11, 0, 0, 0, "sub_self_zero");
    do_op(5, 0, 0, 0, 0, 0, "sub_r0_r0");
    do_op(0, 0, 0, 0, 0, 0, "cleared");

    do_op(2, 0, 0, 2, 16'h0001, 0, "ld_one");
    do_op(2, 0, 0, 3, 16'hFFFF, 0, "ld_ffff");
    do_op(4, 3, 2, 4, 0, 0, "add_to_neg");
    do_op(5, 2, 4, 0, 0, 0, "sub_pos_neg_ovf");
    do_op(5, 4, 3, 0, 0, 0, "sub_neg_pos");
    do_op(7, 1, 2, 0, 0, 0, "reserved_nop");

    for (int k = 0; k < 400; k++) begin
      if (k % 4 == 3)
        do_op(1, $urandom_range(0, 15), 0, 0, 0, 0, "rand_observe");
      else
        do_op($urandom_range(0, 7), $urandom_range(0, 15),
              $urandom_range(0, 15), $urandom_range(0, 15),
              $urandom_range(0, 65535), $urandom_range(0, 65535),
              "rand_op");
    end

    do_op(2, 0, 0, 0, 16'h0777, 0, "ld_r0_777");
    do_op(0, 0, 0, 0, 0, 0, "pre_reset");
    @(posedge clk);
    #2 n_rst = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 0;
    repeat (2) @(posedge clk);
    #2 n_rst = 1'b1;
    for (int r = 0; r < 16; r++) observe(r, "reg_zero_after_midreset");

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: pending=%0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
